// File: rtl/mcpu_pkg.sv
// Shared MCPU constants, loader state encoding and the frame checksum helper.
package mcpu_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int ADDR_SIZE   = 8;
    localparam int OPCODE_SIZE = 4;
    localparam int RAM_SIZE    = 2 ** ADDR_SIZE;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } loader_state_t;

    // Running XOR over the data bytes of a frame.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes a program image into MCPU RAM and holds
// the CPU in reset until a frame with a good checksum has been loaded.
module program_loader #(
    parameter int         WORD_SIZE = mcpu_pkg::WORD_SIZE,
    parameter int         ADDR_SIZE = mcpu_pkg::ADDR_SIZE,
    parameter logic [7:0] SYNC_BYTE = mcpu_pkg::SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_SIZE:0]   words_loaded
);
    import mcpu_pkg::*;

    localparam logic [ADDR_SIZE:0] FULL_FRAME = (ADDR_SIZE+1)'(2 ** ADDR_SIZE);

    loader_state_t        state_r;
    logic [ADDR_SIZE:0]   len_r;
    logic [ADDR_SIZE-1:0] addr_r;
    logic [7:0]           hi_r;
    logic [7:0]           chk_r;
    logic                 accept_s;

    assign accept_s = in_valid && in_ready;

    // Frame FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            len_r        <= '0;
            addr_r       <= '0;
            hi_r         <= 8'h00;
            chk_r        <= 8'h00;
            in_ready     <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            in_ready <= 1'b1;
            ram_we   <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state_r <= S_LEN;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_LEN: begin
                        // A zero length byte encodes a full-RAM image.
                        len_r        <= (in_data == 8'h00) ? FULL_FRAME : (ADDR_SIZE+1)'(in_data);
                        chk_r        <= 8'h00;
                        addr_r       <= '0;
                        words_loaded <= '0;
                        state_r      <= S_HI;
                    end
                    S_HI: begin
                        hi_r    <= in_data;
                        chk_r   <= chk_update(chk_r, in_data);
                        state_r <= S_LO;
                    end
                    S_LO: begin
                        chk_r        <= chk_update(chk_r, in_data);
                        ram_we       <= 1'b1;
                        ram_addr     <= addr_r;
                        ram_wdata    <= WORD_SIZE'({hi_r, in_data});
                        addr_r       <= addr_r + ADDR_SIZE'(1);
                        words_loaded <= words_loaded + (ADDR_SIZE+1)'(1);
                        if ((words_loaded + (ADDR_SIZE+1)'(1)) == len_r) begin
                            state_r <= S_CHK;
                        end else begin
                            state_r <= S_HI;
                        end
                    end
                    S_CHK: begin
                        busy <= 1'b0;
                        if (in_data == chk_r) begin
                            state_r   <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state_r <= S_ERR;
                            err     <= 1'b1;
                        end
                    end
                    S_DONE, S_ERR: begin
                        if (in_data == SYNC_BYTE) begin
                            state_r   <= S_LEN;
                            done      <= 1'b0;
                            err       <= 1'b0;
                            cpu_reset <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised frame-level bench for program_loader with a write scoreboard.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  words_loaded;

    int errors = 0;
    int checks = 0;

    logic [15:0] words [256];
    logic [23:0] exp_q [$];
    logic        prev_we = 1'b0;

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (!reset && ram_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {31'd0, ram_we}, 32'd0);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {24'd0, ram_addr}, {24'd0, e[23:16]});
                check("wr_data", {16'd0, ram_wdata}, {16'd0, e[15:0]});
            end
            check("we_overlap", {31'd0, prev_we & ram_we}, 32'd0);
        end
        prev_we = ram_we;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offers one byte, starting and ending at a falling edge.
    task automatic send(input logic [7:0] b, input bit gaps);
        bit acc;
        bit rdy;
        acc = 1'b0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            rdy = in_ready;
            @(posedge clk);
            acc = rdy;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!acc) check("send_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Sends a whole frame built from words[0..n-1] and checks the outcome.
    task automatic run_frame(input int n, input bit bad, input bit gaps);
        logic [7:0] c;
        c = 8'h00;
        send(8'hA5, gaps);
        check("sync_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("sync_done", {31'd0, done}, 32'd0);
        check("sync_busy", {31'd0, busy}, 32'd1);
        send((n == 256) ? 8'h00 : 8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), words[i]});
            send(words[i][15:8], gaps);
            send(words[i][7:0], gaps);
            c = c ^ words[i][15:8] ^ words[i][7:0];
        end
        send(bad ? (c ^ 8'h01) : c, gaps);
        check("end_done", {31'd0, done}, {31'd0, !bad});
        check("end_err", {31'd0, err}, {31'd0, bad});
        check("end_cpu_reset", {31'd0, cpu_reset}, {31'd0, bad});
        check("end_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
        check("words_loaded", {23'd0, words_loaded}, 32'(n));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        check({tag, "_ram_addr"}, {24'd0, ram_addr}, 32'd0);
        check({tag, "_ram_wdata"}, {16'd0, ram_wdata}, 32'd0);
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_words"}, {23'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Three-word frame, then the same frame with a corrupted checksum.
        words[0] = 16'h100F; words[1] = 16'h2000; words[2] = 16'hF105;
        run_frame(3, 1'b0, 1'b0);
        run_frame(3, 1'b1, 1'b0);

        // Junk before a frame whose data contains the sync value.
        send(8'h00, 1'b0); send(8'hFF, 1'b0); send(8'h12, 1'b0);
        check("junk_no_busy", {31'd0, busy}, 32'd0);
        words[0] = 16'hA55A;
        run_frame(1, 1'b0, 1'b0);

        // Full 256-word image.
        for (int i = 0; i < 256; i++) words[i] = 16'(i);
        run_frame(256, 1'b0, 1'b0);

        // Reload after DONE with stalls between bytes, then random frames.
        words[0] = 16'($urandom); words[1] = 16'($urandom);
        run_frame(2, 1'b0, 1'b1);
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) words[i] = 16'($urandom);
            run_frame(n, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Reset after the high byte of word 2.
        words[0] = 16'h1234; words[1] = 16'h5678;
        send(8'hA5, 1'b0); send(8'h03, 1'b0);
        exp_q.push_back({8'h00, words[0]});
        send(words[0][15:8], 1'b0); send(words[0][7:0], 1'b0);
        send(words[1][15:8], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        run_frame(3, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
